// File: rtl/fft_peak_finder_pkg.sv
// Shared types and constants for the FFT peak finder: FSM encoding,
// flush length and the first bin eligible for the peak search.
package fft_peak_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        FLUSH
    } state_t;

    localparam int unsigned FLUSH_CYCLES = 3;
    localparam int unsigned FLUSH_CNT_W  = $clog2(FLUSH_CYCLES);

    function automatic int unsigned first_bin(input int unsigned skip_dc);
        return (skip_dc != 0) ? 1 : 0;
    endfunction

endpackage

// File: rtl/fft_peak_finder_if.sv
// AXI4-Stream link carrying complex FFT bins (im in the upper half, re in the lower).
interface fft_peak_finder_if #(
    parameter int unsigned DATA_WIDTH = 16
);
    logic [2*DATA_WIDTH-1:0] m_axis_data_tdata;
    logic                    m_axis_data_tvalid;
    logic                    m_axis_data_tlast;
    logic                    m_axis_data_tready;

    modport master (
        output m_axis_data_tdata,
        output m_axis_data_tvalid,
        output m_axis_data_tlast,
        input  m_axis_data_tready
    );

    modport slave (
        input  m_axis_data_tdata,
        input  m_axis_data_tvalid,
        input  m_axis_data_tlast,
        output m_axis_data_tready
    );
endinterface

// File: rtl/fft_peak_finder_mag_sq_pipe.sv
// Two-stage |X|^2 pipeline: stage 1 squares re and im, stage 2 sums them.
// Bin index and end-of-frame flag travel alongside the valid bit.
module mag_sq_pipe #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned IDX_W      = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [2*DATA_WIDTH-1:0] in_data,
    input  logic [IDX_W-1:0]        in_index,
    input  logic                    in_end,
    output logic                    out_valid,
    output logic [2*DATA_WIDTH-1:0] out_mag,
    output logic [IDX_W-1:0]        out_index,
    output logic                    out_end
);
    localparam int unsigned W = DATA_WIDTH;

    logic signed [W-1:0]   re;
    logic signed [W-1:0]   im;
    logic signed [2*W-1:0] re_prod;
    logic signed [2*W-1:0] im_prod;

    logic                  s1_valid;
    logic [2*W-2:0]        s1_re_sq;
    logic [2*W-2:0]        s1_im_sq;
    logic [IDX_W-1:0]      s1_index;
    logic                  s1_end;

    assign re = in_data[W-1:0];
    assign im = in_data[2*W-1:W];

    // A square is never negative and peaks at 2^(2W-2), so the top bit is always zero.
    assign re_prod = (2*W)'(re) * (2*W)'(re);
    assign im_prod = (2*W)'(im) * (2*W)'(im);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_re_sq  <= '0;
            s1_im_sq  <= '0;
            s1_index  <= '0;
            s1_end    <= 1'b0;
            out_valid <= 1'b0;
            out_mag   <= '0;
            out_index <= '0;
            out_end   <= 1'b0;
        end else begin
            s1_valid  <= in_valid;
            s1_re_sq  <= re_prod[2*W-2:0];
            s1_im_sq  <= im_prod[2*W-2:0];
            s1_index  <= in_index;
            s1_end    <= in_valid & in_end;
            out_valid <= s1_valid;
            out_mag   <= {1'b0, s1_re_sq} + {1'b0, s1_im_sq};
            out_index <= s1_index;
            out_end   <= s1_valid & s1_end;
        end
    end

endmodule

// File: rtl/fft_peak_finder.sv
// Per-frame peak search over the FFT output: counts bins, squares magnitudes
// through mag_sq_pipe and reports the strongest bin in the lower half spectrum.
module fft_peak_finder
    import fft_peak_pkg::*;
#(
    parameter int unsigned FFT_LEN    = 1024,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned SKIP_DC    = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    fft_peak_finder_if.slave            m_axis_data,
    output logic [$clog2(FFT_LEN)-1:0]  peak_index,
    output logic [2*DATA_WIDTH-1:0]     peak_mag,
    output logic                        peak_valid,
    output logic                        frame_err
);
    localparam int unsigned IDX_W = $clog2(FFT_LEN);
    localparam logic [IDX_W-1:0] FIRST_BIN = IDX_W'(first_bin(SKIP_DC));

    state_t                   state;
    state_t                   state_nxt;
    logic [FLUSH_CNT_W-1:0]   flush_cnt;
    logic [IDX_W-1:0]         bin_k;
    logic                     err_flag;
    logic                     tready;
    logic                     accept;
    logic                     last_bin;
    logic                     eof;

    logic                     s2_valid;
    logic [2*DATA_WIDTH-1:0]  s2_mag;
    logic [IDX_W-1:0]         s2_index;
    logic                     s2_end;

    logic [2*DATA_WIDTH-1:0]  max_mag;
    logic [IDX_W-1:0]         max_idx;
    logic                     in_range;
    logic                     take;
    logic [2*DATA_WIDTH-1:0]  cand_mag;
    logic [IDX_W-1:0]         cand_idx;

    // Held low through reset so nothing is accepted before IDLE is established.
    assign tready   = !rst && (state != FLUSH);
    assign m_axis_data.m_axis_data_tready = tready;

    assign accept   = m_axis_data.m_axis_data_tvalid & tready;
    assign last_bin = (bin_k == IDX_W'(FFT_LEN - 1));
    assign eof      = accept & (m_axis_data.m_axis_data_tlast | last_bin);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = eof ? FLUSH : ACCUM;
            ACCUM:   if (eof) state_nxt = FLUSH;
            FLUSH:   if (flush_cnt == FLUSH_CNT_W'(FLUSH_CYCLES - 1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            flush_cnt <= '0;
            bin_k     <= '0;
            err_flag  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == FLUSH) flush_cnt <= flush_cnt + 1'b1;
            else                flush_cnt <= '0;
            if (eof) begin
                bin_k    <= '0;
                err_flag <= m_axis_data.m_axis_data_tlast ? !last_bin : last_bin;
            end else if (accept) begin
                bin_k <= bin_k + 1'b1;
            end
        end
    end

    mag_sq_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_W      (IDX_W)
    ) u_mag_sq_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (accept),
        .in_data   (m_axis_data.m_axis_data_tdata),
        .in_index  (bin_k),
        .in_end    (eof),
        .out_valid (s2_valid),
        .out_mag   (s2_mag),
        .out_index (s2_index),
        .out_end   (s2_end)
    );

    assign in_range = (s2_index < IDX_W'(FFT_LEN / 2)) && !((SKIP_DC != 0) && (s2_index == '0));
    assign take     = s2_valid && in_range && (s2_mag > max_mag);
    assign cand_mag = take ? s2_mag : max_mag;
    assign cand_idx = take ? s2_index : max_idx;

    // The final bin reaches stage 2 on the same edge the result is published,
    // so the report is taken from the comparator output rather than the register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_mag    <= '0;
            max_idx    <= FIRST_BIN;
            peak_index <= '0;
            peak_mag   <= '0;
            peak_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            peak_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (s2_valid && s2_end) begin
                peak_index <= cand_idx;
                peak_mag   <= cand_mag;
                peak_valid <= 1'b1;
                frame_err  <= err_flag;
                max_mag    <= '0;
                max_idx    <= FIRST_BIN;
            end else begin
                max_mag <= cand_mag;
                max_idx <= cand_idx;
            end
        end
    end

endmodule
